microsequencer: RTL and testbench

//  Parametrised microprogram sequencer; next generation of the ARC control section. Computes
//  the control-store address, registers the MIR and drives it to the datapath. Adds over the

---
 rtl/usequencer_pkg.sv | 49 ++++
 rtl/ustack.sv | 54 +++++
 rtl/microsequencer.sv | 145 ++++++++++++++
 tb/tb_microsequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/usequencer_pkg.sv
// Shared definitions for the microprogram sequencer: MIR field codes, field offsets
// relative to the jump-address field, and the branch-condition helper.
package usequencer_pkg;

   typedef enum logic [2:0] {
      COND_SEQ    = 3'b000,
      COND_N      = 3'b001,
      COND_Z      = 3'b010,
      COND_V      = 3'b011,
      COND_C      = 3'b100,
      COND_IR13   = 3'b101,
      COND_JUMP   = 3'b110,
      COND_DECODE = 3'b111
   } cond_e;

   typedef enum logic [1:0] {
      SOP_NONE = 2'b00,
      SOP_CALL = 2'b01,
      SOP_RET  = 2'b10,
      SOP_RSVD = 2'b11
   } sop_e;

   // Bit offsets above JADDR; the sequencer owns the low ADDR_W+SEQ_FIELDS_W bits.
   localparam int COND_OFS     = 0;
   localparam int SOP_OFS      = 3;
   localparam int WAIT_OFS     = 5;
   localparam int SEQ_FIELDS_W = 6;

   // Every bit of a NOP microinstruction takes this value.
   localparam logic NOP_MIR_BIT = 1'b0;

   // flags = {N,Z,V,C}; true when the condition selects JADDR.
   function automatic logic cond_taken(input cond_e cond, input logic [3:0] flags,
                                       input logic ir13);
      logic taken;
      taken = 1'b0;
      case (cond)
         COND_N:    taken = flags[3];
         COND_Z:    taken = flags[2];
         COND_V:    taken = flags[1];
         COND_C:    taken = flags[0];
         COND_IR13: taken = ir13;
         COND_JUMP: taken = 1'b1;
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/ustack.sv
// Micro-subroutine return stack: DEPTH x W LIFO. Push on full and pop on empty are
// ignored here; the sequencer turns them into sticky error flags.
module ustack #(
   parameter int DEPTH = 4,
   parameter int W     = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] sp_q, sp_d;
   logic [W-1:0]     mem_q [DEPTH];
   logic [IDX_W-1:0] wr_idx, top_idx;

   assign full    = (sp_q == PTR_W'(DEPTH));
   assign empty   = (sp_q == '0);
   assign wr_idx  = IDX_W'(sp_q);
   assign top_idx = IDX_W'(sp_q - PTR_W'(1));
   assign top     = mem_q[top_idx];

   always_comb begin
      sp_d = sp_q;
      if (push && !full) begin
         sp_d = sp_q + PTR_W'(1);
      end else if (pop && !empty) begin
         sp_d = sp_q - PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // NOTE: entries carry no reset; the pointer alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[wr_idx] <= wdata;
      end
   end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: selects the next control-store address, registers the MIR
// and holds it on memory wait; supports micro-calls, returns and trap vectoring.
module microsequencer
   import usequencer_pkg::*;
#(
   parameter int ADDR_W     = 11,
   parameter int MIR_W      = 44,
   parameter int STACK_D    = 4,
   parameter int RESET_ADDR = 0,
   parameter int TRAP_ADDR  = 1792
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ir,
   input  logic [3:0]        psr,
   input  logic              ack,
   input  logic              trap_req,
   output logic [ADDR_W-1:0] cs_addr,
   input  logic [MIR_W-1:0]  cs_data,
   output logic [MIR_W-1:0]  mir,
   output logic              stall,
   output logic              trap_ack,
   output logic              stk_ovf,
   output logic              stk_unf
);

   localparam logic [ADDR_W-1:0] RST_A  = ADDR_W'(RESET_ADDR);
   localparam logic [ADDR_W-1:0] TRAP_A = ADDR_W'(TRAP_ADDR);

   logic [MIR_W-1:0]  mir_q, mir_d;
   logic [ADDR_W-1:0] upc_q, upc_d;
   logic              valid_q, valid_d;
   logic              stk_ovf_q, stk_ovf_d;
   logic              stk_unf_q, stk_unf_d;

   logic [ADDR_W-1:0] jaddr, upc_inc, decode_addr, seq_addr, next_addr;
   logic [ADDR_W-1:0] push_data, stk_top;
   cond_e             cond;
   sop_e              sop;
   logic              wait_f, stall_c, trap_c, push, pop, stk_full, stk_empty;
   logic              unused_ir;

   assign jaddr       = mir_q[ADDR_W-1:0];
   assign cond        = cond_e'(mir_q[ADDR_W+COND_OFS +: 3]);
   assign sop         = sop_e'(mir_q[ADDR_W+SOP_OFS +: 2]);
   assign wait_f      = mir_q[ADDR_W+WAIT_OFS];
   assign upc_inc     = upc_q + ADDR_W'(1);
   assign decode_addr = {1'b1, ir[31:30], ir[24:19], {(ADDR_W-9){1'b0}}};
   assign unused_ir   = ^{ir[29:25], ir[18:14], ir[12:0]};

   always_comb begin
      if (cond == COND_DECODE) begin
         seq_addr = decode_addr;
      end else if (cond_taken(cond, psr, ir[13])) begin
         seq_addr = jaddr;
      end else begin
         seq_addr = upc_inc;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      next_addr = seq_addr;
      push_data = upc_inc;
      push      = 1'b0;
      pop       = 1'b0;
      stall_c   = 1'b0;
      trap_c    = 1'b0;
      stk_ovf_d = stk_ovf_q;
      stk_unf_d = stk_unf_q;
      if (!valid_q) begin
         next_addr = RST_A;
      end else if (wait_f && !ack) begin
         stall_c   = 1'b1;
         next_addr = upc_q;
      end else if (trap_req && (sop == SOP_NONE || sop == SOP_RSVD)) begin
         trap_c    = 1'b1;
         next_addr = TRAP_A;
         push      = 1'b1;
         push_data = seq_addr;
      end else begin
         case (sop)
            SOP_CALL: begin
               next_addr = jaddr;
               push      = 1'b1;
            end
            SOP_RET: begin
               if (stk_empty) begin
                  next_addr = RST_A;
                  stk_unf_d = 1'b1;
               end else begin
                  next_addr = stk_top;
                  pop       = 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (push && stk_full) begin
         stk_ovf_d = 1'b1;
      end
      mir_d   = stall_c ? mir_q : cs_data;
      upc_d   = stall_c ? upc_q : next_addr;
      valid_d = 1'b1;
   end

   // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         mir_q     <= {MIR_W{NOP_MIR_BIT}};
         upc_q     <= '0;
         valid_q   <= 1'b0;
         stk_ovf_q <= 1'b0;
         stk_unf_q <= 1'b0;
      end else begin
         mir_q     <= mir_d;
         upc_q     <= upc_d;
         valid_q   <= valid_d;
         stk_ovf_q <= stk_ovf_d;
         stk_unf_q <= stk_unf_d;
      end
   end

   ustack #(
      .DEPTH (STACK_D),
      .W     (ADDR_W)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (push_data),
      .top   (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

   assign cs_addr  = next_addr;
   assign mir      = mir_q;
   assign stall    = stall_c;
   assign trap_ack = trap_c;
   assign stk_ovf  = stk_ovf_q;
   assign stk_unf  = stk_unf_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: table of single-step branch vectors against a
// bench-owned control store, plus hand sequences for stall, call/ret, trap and stack errors.
module tb_microsequencer;

   logic        clk = 1'b0;
   logic        rst, ack, trap_req;
   logic [31:0] ir;
   logic [3:0]  psr;
   logic [10:0] cs_addr;
   logic [43:0] cs_data, mir;
   logic        stall, trap_ack, stk_ovf, stk_unf;

   logic [43:0] rom [2048];
   assign cs_data = rom[cs_addr];

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0]  cond;
      logic [10:0] jaddr;
      logic [3:0]  psr;
      logic [31:0] ir;
      logic [10:0] exp_addr;
   } vec_t;

   vec_t vecs [14];

   microsequencer #(
      .ADDR_W     (11),
      .MIR_W      (44),
      .STACK_D    (4),
      .RESET_ADDR (0),
      .TRAP_ADDR  (1792)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ir       (ir),
      .psr      (psr),
      .ack      (ack),
      .trap_req (trap_req),
      .cs_addr  (cs_addr),
      .cs_data  (cs_data),
      .mir      (mir),
      .stall    (stall),
      .trap_ack (trap_ack),
      .stk_ovf  (stk_ovf),
      .stk_unf  (stk_unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {payload[26:0], WAIT, SOP[1:0], COND[2:0], JADDR[10:0]}
   function automatic logic [43:0] mk(input logic [10:0] j, input logic [2:0] c,
                                      input logic [1:0] s, input logic w,
                                      input logic [26:0] dp);
      return {dp, w, s, c, j};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      ack      = 1'b1;
      trap_req = 1'b0;
      psr      = 4'h0;
      ir       = 32'h0;
      for (int i = 0; i < 2048; i++) rom[i] = '0;
      tick();
      tick();
      check("rst mir", 64'(mir), 64'h0);
      check("rst cs_addr", 64'(cs_addr), 64'h0);
      check("rst stall", 64'(stall), 64'h0);
      check("rst trap_ack", 64'(trap_ack), 64'h0);
      check("rst stk_ovf", 64'(stk_ovf), 64'h0);
      check("rst stk_unf", 64'(stk_unf), 64'h0);
      rst = 1'b0;
   endtask

   initial begin
      logic [43:0] w0;

      vecs[0]  = '{3'b000, 11'h155, 4'b1111, 32'h0000_0000, 11'h001};
      vecs[1]  = '{3'b001, 11'h155, 4'b1000, 32'h0000_0000, 11'h155};
      vecs[2]  = '{3'b001, 11'h155, 4'b0111, 32'h0000_0000, 11'h001};
      vecs[3]  = '{3'b010, 11'h020, 4'b0100, 32'h0000_0000, 11'h020};
      vecs[4]  = '{3'b010, 11'h020, 4'b1011, 32'h0000_0000, 11'h001};
      vecs[5]  = '{3'b011, 11'h3A0, 4'b0010, 32'h0000_0000, 11'h3A0};
      vecs[6]  = '{3'b011, 11'h3A0, 4'b1101, 32'h0000_0000, 11'h001};
      vecs[7]  = '{3'b100, 11'h7FF, 4'b0001, 32'h0000_0000, 11'h7FF};
      vecs[8]  = '{3'b100, 11'h7FF, 4'b1110, 32'h0000_0000, 11'h001};
      vecs[9]  = '{3'b101, 11'h0AA, 4'b0000, 32'h0000_2000, 11'h0AA};
      vecs[10] = '{3'b101, 11'h0AA, 4'b1111, 32'hFFFF_DFFF, 11'h001};
      vecs[11] = '{3'b110, 11'h123, 4'b0000, 32'h0000_0000, 11'h123};
      vecs[12] = '{3'b111, 11'h123, 4'b0000, 32'h8080_0000, 11'h640};
      vecs[13] = '{3'b111, 11'h000, 4'b1111, 32'h41FF_FFFF, 11'h5FC};

      // Single step from upc=0: first MIR after reset decides the next address.
      for (int i = 0; i < 14; i++) begin
         do_reset();
         rom[0] = mk(vecs[i].jaddr, vecs[i].cond, 2'b00, 1'b0, 27'(i + 1));
         psr    = vecs[i].psr;
         ir     = vecs[i].ir;
         tick();
         check($sformatf("vec%0d mir", i), 64'(mir), 64'(rom[0]));
         check($sformatf("vec%0d cs_addr", i), 64'(cs_addr), 64'(vecs[i].exp_addr));
      end

      // Stall on WAIT with ack low; trap ignored while stalled; reset mid-stall.
      do_reset();
      w0     = mk(11'h000, 3'b000, 2'b00, 1'b1, 27'h0ABCDEF);
      rom[0] = w0;
      rom[1] = mk(11'h000, 3'b000, 2'b00, 1'b0, 27'h0111111);
      rom[2] = mk(11'h000, 3'b000, 2'b00, 1'b1, 27'h0222222);
      ack    = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         trap_req = (k == 1);
         #1;
         check($sformatf("stall%0d stall", k), 64'(stall), 64'h1);
         check($sformatf("stall%0d mir", k), 64'(mir), 64'(w0));
         check($sformatf("stall%0d cs_addr", k), 64'(cs_addr), 64'h0);
         check($sformatf("stall%0d trap_ack", k), 64'(trap_ack), 64'h0);
         tick();
      end
      trap_req = 1'b0;
      ack      = 1'b1;
      #1;
      check("stall release stall", 64'(stall), 64'h0);
      check("stall release cs_addr", 64'(cs_addr), 64'h1);
      tick();
      check("stall advance mir", 64'(mir), 64'(rom[1]));
      check("stall advance cs_addr", 64'(cs_addr), 64'h2);
      tick();
      ack = 1'b0;
      #1;
      check("stall2 stall", 64'(stall), 64'h1);
      rst = 1'b1;
      tick();
      check("rst mid-stall mir", 64'(mir), 64'h0);
      check("rst mid-stall stall", 64'(stall), 64'h0);
      check("rst mid-stall cs_addr", 64'(cs_addr), 64'h0);
      rst = 1'b0;

      // Call 0x100 from upc=0x10, return to 0x11.
      do_reset();
      rom[11'h000] = mk(11'h010, 3'b110, 2'b00, 1'b0, 27'h0);
      rom[11'h010] = mk(11'h100, 3'b000, 2'b01, 1'b0, 27'h0);
      rom[11'h100] = mk(11'h000, 3'b000, 2'b10, 1'b0, 27'h0);
      tick();
      check("call jump cs_addr", 64'(cs_addr), 64'h010);
      tick();
      check("call cs_addr", 64'(cs_addr), 64'h100);
      tick();
      check("ret cs_addr", 64'(cs_addr), 64'h011);
      tick();
      check("after ret cs_addr", 64'(cs_addr), 64'h012);
      check("call stk_ovf", 64'(stk_ovf), 64'h0);
      check("call stk_unf", 64'(stk_unf), 64'h0);

      // Five nested calls with a 4-deep stack: fifth push dropped, stk_ovf set.
      do_reset();
      rom[11'h000] = mk(11'h210, 3'b000, 2'b01, 1'b0, 27'h0);
      rom[11'h210] = mk(11'h220, 3'b000, 2'b01, 1'b0, 27'h0);
      rom[11'h220] = mk(11'h230, 3'b000, 2'b01, 1'b0, 27'h0);
      rom[11'h230] = mk(11'h240, 3'b000, 2'b01, 1'b0, 27'h0);
      rom[11'h240] = mk(11'h250, 3'b000, 2'b01, 1'b0, 27'h0);
      rom[11'h250] = mk(11'h000, 3'b000, 2'b10, 1'b0, 27'h0);
      rom[11'h231] = mk(11'h000, 3'b000, 2'b10, 1'b0, 27'h0);
      repeat (5) tick();
      check("ovf fifth call cs_addr", 64'(cs_addr), 64'h250);
      check("ovf before full push", 64'(stk_ovf), 64'h0);
      tick();
      check("ovf flag", 64'(stk_ovf), 64'h1);
      check("ovf ret cs_addr", 64'(cs_addr), 64'h231);
      tick();
      check("ovf second ret cs_addr", 64'(cs_addr), 64'h221);
      check("ovf sticky", 64'(stk_ovf), 64'h1);

      // Trap at upc=0x30 with SOP=00, handler returns to 0x31.
      do_reset();
      rom[11'h000] = mk(11'h030, 3'b110, 2'b00, 1'b0, 27'h0);
      rom[11'h030] = mk(11'h000, 3'b000, 2'b00, 1'b0, 27'h0333333);
      rom[11'h700] = mk(11'h000, 3'b000, 2'b10, 1'b0, 27'h0777777);
      tick();
      tick();
      trap_req = 1'b1;
      #1;
      check("trap cs_addr", 64'(cs_addr), 64'h700);
      check("trap_ack pulse", 64'(trap_ack), 64'h1);
      tick();
      check("trap handler mir", 64'(mir), 64'(rom[11'h700]));
      check("trap_ack one cycle", 64'(trap_ack), 64'h0);
      check("trap ret cs_addr", 64'(cs_addr), 64'h031);
      trap_req = 1'b0;
      tick();
      check("after trap cs_addr", 64'(cs_addr), 64'h032);

      // Return on empty stack: RESET_ADDR and sticky stk_unf.
      do_reset();
      rom[0] = mk(11'h000, 3'b000, 2'b10, 1'b0, 27'h0);
      tick();
      check("unf cs_addr", 64'(cs_addr), 64'h0);
      check("unf before edge", 64'(stk_unf), 64'h0);
      tick();
      check("unf flag", 64'(stk_unf), 64'h1);
      repeat (3) tick();
      check("unf sticky", 64'(stk_unf), 64'h1);
      check("unf no ovf", 64'(stk_ovf), 64'h0);

      // upc+1 wraps modulo 2^ADDR_W.
      do_reset();
      rom[0] = mk(11'h7FF, 3'b110, 2'b00, 1'b0, 27'h0);
      tick();
      check("wrap jump cs_addr", 64'(cs_addr), 64'h7FF);
      tick();
      check("wrap cs_addr", 64'(cs_addr), 64'h000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
